// File: rtl/mem_lsu_port_if.sv
// Load/store handshake bundle between a core's LSU (master) and the memory port (slave).
interface mem_lsu_port_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lsu_port.sv
// Unified instruction/data memory: free-running registered fetch port plus a single-outstanding
// load/store port with programmable wait states, RV32 sizing, lane steering and error checks.
module mem_lsu_port #(
  parameter int    DEPTH_WORDS = 1024,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    insn_addr,
  output logic [31:0]    insn,
  mem_lsu_port_if.slave  lsu
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  f3_q, f3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        rsp_load_q, rsp_load_d;
  logic [2:0]  rsp_f3_q, rsp_f3_d;
  logic [1:0]  rsp_off_q, rsp_off_d;

  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] insn_q;
  logic [31:0] rd_word_q;

  logic          access;
  logic          size_bad;
  logic          misaligned;
  logic          out_of_range;
  logic          req_err;
  logic          mem_we;
  logic [AW-1:0] acc_idx;
  logic [AW-1:0] insn_idx;
  logic [3:0]    lane_be;
  logic [31:0]   lane_wdata;
  logic [7:0]    ld_byte;
  logic [15:0]   ld_half;
  logic [31:0]   ld_ext;
  logic          unused_insn_bits;

  assign access   = (state_q == BUSY) && (cnt_q == 8'd0);
  assign acc_idx  = addr_q[AW+1:2];
  assign insn_idx = insn_addr[AW+1:2];
  assign unused_insn_bits = ^{insn_addr[31:AW+2], insn_addr[1:0]};

  always_comb begin
    size_bad = 1'b1;
    case (f3_q)
      3'b000, 3'b001, 3'b010: size_bad = 1'b0;
      3'b100, 3'b101:         size_bad = we_q;
      default:                size_bad = 1'b1;
    endcase
    misaligned   = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    out_of_range = |addr_q[31:AW+2];
    req_err      = size_bad || misaligned || out_of_range;
  end

  // rst wins over a coinciding access edge so a dropped request never lands in memory.
  assign mem_we = access && we_q && !req_err && !rst;

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign lane_be[gi] = (f3_q[1:0] == 2'b10) ||
                         ((f3_q[1:0] == 2'b01) && (addr_q[1] == LANE[1])) ||
                         ((f3_q[1:0] == 2'b00) && (addr_q[1:0] == LANE));
    assign lane_wdata[8*gi +: 8] = (f3_q[1:0] == 2'b00) ? wdata_q[7:0] :
                                   (f3_q[1:0] == 2'b01) ? wdata_q[8*(gi%2) +: 8] :
                                                          wdata_q[8*gi +: 8];
  end

  // Port A: data read/write at the latched address; the read is captured only on the access edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[acc_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
    if (rst) begin
      rd_word_q <= '0;
    end else if (access) begin
      rd_word_q <= mem[acc_idx];
    end
  end

  // Port B: fetch, read-before-write against port A.
  always_ff @(posedge clk) begin
    if (rst) begin
      insn_q <= '0;
    end else begin
      insn_q <= mem[insn_idx];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_err_d  = rsp_err_q;
    rsp_load_d = rsp_load_q;
    rsp_f3_d   = rsp_f3_q;
    rsp_off_d  = rsp_off_q;
    case (state_q)
      IDLE: begin
        if (lsu.req_valid) begin
          we_d    = lsu.req_we;
          f3_d    = lsu.req_funct3;
          addr_d  = lsu.req_addr;
          wdata_d = lsu.req_wdata;
          cnt_d   = 8'(WAIT_CYCLES);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          rsp_err_d  = req_err;
          rsp_load_d = !we_q && !req_err;
          rsp_f3_d   = f3_q;
          rsp_off_d  = addr_q[1:0];
          state_d    = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_err_q  <= 1'b0;
      rsp_load_q <= 1'b0;
      rsp_f3_q   <= '0;
      rsp_off_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_err_q  <= rsp_err_d;
      rsp_load_q <= rsp_load_d;
      rsp_f3_q   <= rsp_f3_d;
      rsp_off_q  <= rsp_off_d;
    end
  end

  // Load extension works off held registers, so the result stays stable until the next response.
  always_comb begin
    ld_byte = rd_word_q[{rsp_off_q, 3'b000} +: 8];
    ld_half = rsp_off_q[1] ? rd_word_q[31:16] : rd_word_q[15:0];
    case (rsp_f3_q)
      3'b000:  ld_ext = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_ext = {24'd0, ld_byte};
      3'b001:  ld_ext = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_ext = {16'd0, ld_half};
      default: ld_ext = rd_word_q;
    endcase
  end

  assign insn          = insn_q;
  assign lsu.req_ready = (state_q == IDLE);
  assign lsu.rsp_valid = (state_q == RESP);
  assign lsu.rsp_err   = rsp_err_q;
  assign lsu.rsp_rdata = rsp_load_q ? ld_ext : 32'd0;
endmodule
